// File: rtl/cpu_mem_pkg.sv
// Shared CPU memory-side types: sequencer states,
// requester ids and response error codes.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic REQ_IFETCH = 1'b0;
  localparam logic REQ_DATA   = 1'b1;

  localparam logic ERR_NONE    = 1'b0;
  localparam logic ERR_TIMEOUT = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-port bundle of mem_port_arbiter.
// master = arbiter side, slave = requesters + memory.
interface mem_port_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0]      req_we;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      resp_valid;
  logic            resp_err;
  logic [DW-1:0]   resp_rdata;
  logic            mem_req;
  logic            mem_gnt;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_rvalid;
  logic [DW-1:0]   mem_rdata;

  modport master (
    input  req_valid, req_we, req_addr,
    input  req_wdata, mem_gnt,
    input  mem_rvalid, mem_rdata,
    output req_ready, resp_valid,
    output resp_err, resp_rdata,
    output mem_req, mem_we,
    output mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_addr,
    output req_wdata, mem_gnt,
    output mem_rvalid, mem_rdata,
    input  req_ready, resp_valid,
    input  resp_err, resp_rdata,
    input  mem_req, mem_we,
    input  mem_addr, mem_wdata
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant, combinational.
// i_req: requests, i_last: last winner id, o_gnt: one-hot.
module rr_arbiter2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);
  // On a tie the requester that did not win last time wins.
  assign o_gnt[0] = i_req[0] & (~i_req[1] | i_last);
  assign o_gnt[1] = i_req[1] & (~i_req[0] | ~i_last);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between ifetch and data paths.
// clk/rst_n plain; everything else via bus (master).
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic rst_n,
  mem_port_arbiter_if.master bus
);
  localparam int CW = (TIMEOUT_CYCLES < 1) ? 1
                    : $clog2(TIMEOUT_CYCLES + 1);

  state_t                r_state;
  state_t                w_next;
  logic                  r_last;
  logic                  r_owner;
  logic [CW-1:0]         r_cnt;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [1:0]            r_resp_valid;
  logic                  r_resp_err;
  logic [DATA_WIDTH-1:0] r_resp_rdata;
  logic [1:0]            w_gnt;
  logic                  w_acc;
  logic                  w_sel;
  logic                  w_expire;

  rr_arbiter2 u_arb (
    .i_req  (bus.req_valid),
    .i_last (r_last),
    .o_gnt  (w_gnt)
  );

  // Grant is already masked by req_valid.
  assign bus.req_ready = (r_state == IDLE) ? w_gnt : 2'b00;
  assign w_acc = (r_state == IDLE) && (|w_gnt);
  assign w_sel = w_gnt[REQ_DATA];

  // r_cnt holds completed WAIT cycles; the error fires
  // once TIMEOUT_CYCLES of them have gone by.
  assign w_expire = (TIMEOUT_CYCLES != 0) &&
                    (r_cnt == CW'(TIMEOUT_CYCLES));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_acc) w_next = ISSUE;
      ISSUE:   if (bus.mem_gnt) w_next = WAIT;
      WAIT:    if (bus.mem_rvalid || w_expire)
                 w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last       <= REQ_DATA;
      r_owner      <= REQ_IFETCH;
      r_cnt        <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_resp_valid <= 2'b00;
      r_resp_err   <= ERR_NONE;
      r_resp_rdata <= '0;
    end else begin
      r_state      <= w_next;
      r_resp_valid <= 2'b00;
      unique case (r_state)
        IDLE: if (w_acc) begin
          r_mem_req   <= 1'b1;
          r_mem_we    <= bus.req_we[w_sel];
          r_mem_addr  <= w_sel
            ? bus.req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
            : bus.req_addr[ADDR_WIDTH-1:0];
          r_mem_wdata <= w_sel
            ? bus.req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
            : bus.req_wdata[DATA_WIDTH-1:0];
          r_owner     <= w_sel;
          r_last      <= w_sel;
        end
        ISSUE: if (bus.mem_gnt) begin
          r_mem_req <= 1'b0;
          r_cnt     <= '0;
        end
        WAIT: begin
          if (bus.mem_rvalid) begin
            r_resp_valid <= r_owner ? 2'b10 : 2'b01;
            r_resp_err   <= ERR_NONE;
            r_resp_rdata <= r_mem_we ? '0
                                     : bus.mem_rdata;
          end else if (w_expire) begin
            r_resp_valid <= r_owner ? 2'b10 : 2'b01;
            r_resp_err   <= ERR_TIMEOUT;
            r_resp_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_req    = r_mem_req;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter.
// Uses TIMEOUT_CYCLES = 4.
module tb_mem_port_arbiter;
  import cpu_mem_pkg::*;

  localparam int TO = 4;

  typedef struct packed {
    logic        owner;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errs = 0;
  int   checks = 0;
  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DW(32), .AW(32)) bus ();

  mem_port_arbiter #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (32),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every resp_valid pops one entry.
  always @(negedge clk) begin
    if (bus.resp_valid != 2'b00) begin
      if (q.size() == 0) begin
        chk("stray_resp", 64'(bus.resp_valid), 0);
      end else begin
        e = q.pop_front();
        chk("sb_owner", 64'(bus.resp_valid),
            e.owner ? 64'h2 : 64'h1);
        chk("sb_err", 64'(bus.resp_err), 64'(e.err));
        chk("sb_rdata", 64'(bus.resp_rdata),
            64'(e.rdata));
      end
    end
  end

  // One transaction from an IDLE cycle. rdly < 0 means
  // mem_rvalid never comes.
  task automatic txn(input logic [1:0] vld,
                     input int g,
                     input logic hold,
                     input int gdly,
                     input int rdly,
                     input logic [31:0] rd,
                     input logic eerr);
    logic [31:0] a;
    logic [31:0] w;
    logic        we_b;
    int          n;
    bus.req_valid = vld;
    #1;
    chk("ready", 64'(bus.req_ready), 64'(2'b01 << g));
    a = (g == 1) ? bus.req_addr[63:32]
                 : bus.req_addr[31:0];
    w = (g == 1) ? bus.req_wdata[63:32]
                 : bus.req_wdata[31:0];
    we_b = bus.req_we[g];
    q.push_back('{owner: 1'(g), err: eerr,
                  rdata: (eerr || we_b) ? 32'h0 : rd});
    step();
    if (!hold) bus.req_valid = 2'b00;
    chk("mem_req", 64'(bus.mem_req), 1);
    chk("mem_addr", 64'(bus.mem_addr), 64'(a));
    chk("mem_we", 64'(bus.mem_we), 64'(we_b));
    chk("mem_wdata", 64'(bus.mem_wdata), 64'(w));
    chk("ready_busy", 64'(bus.req_ready), 0);
    for (int i = 0; i < gdly; i++) begin
      step();
      chk("req_hold", 64'(bus.mem_req), 1);
      chk("addr_hold", 64'(bus.mem_addr), 64'(a));
      chk("wdata_hold", 64'(bus.mem_wdata), 64'(w));
      chk("we_hold", 64'(bus.mem_we), 64'(we_b));
    end
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    chk("req_drop", 64'(bus.mem_req), 0);
    n = 0;
    if (rdly >= 0) begin
      repeat (rdly) step();
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = rd;
      step();
      bus.mem_rvalid = 1'b0;
      n = rdly + 1;
    end
    while (bus.resp_valid == 2'b00 && n < 40) begin
      step();
      n++;
    end
    chk("resp_lat", 64'(n),
        64'(eerr ? TO + 1 : rdly + 1));
    chk("resp_to_owner", 64'(bus.resp_valid),
        64'(2'b01 << g));
    step();
    chk("resp_one_cycle", 64'(bus.resp_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bus.req_valid  = 2'b00;
    bus.req_we     = 2'b00;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    #12;
    chk("rst_ready", 64'(bus.req_ready), 0);
    chk("rst_rvalid", 64'(bus.resp_valid), 0);
    chk("rst_rerr", 64'(bus.resp_err), 0);
    chk("rst_rdata", 64'(bus.resp_rdata), 0);
    chk("rst_mreq", 64'(bus.mem_req), 0);
    chk("rst_mwe", 64'(bus.mem_we), 0);
    chk("rst_maddr", 64'(bus.mem_addr), 0);
    chk("rst_mwdata", 64'(bus.mem_wdata), 0);
    #11 rst_n = 1'b1;
    step();

    // Stray mem_rvalid in IDLE.
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1234_5678;
    step();
    step();
    bus.mem_rvalid = 1'b0;
    chk("stray_mreq", 64'(bus.mem_req), 0);
    chk("stray_resp0", 64'(bus.resp_valid), 0);

    // Held tie: 0,1,0,1.
    bus.req_addr  = {32'h0000_2004, 32'h0000_1000};
    bus.req_wdata = {32'h2222_2222, 32'h1111_1111};
    txn(2'b11, REQ_IFETCH, 1'b1, 0, 0,
        32'hA000_0001, 1'b0);
    txn(2'b11, REQ_DATA, 1'b1, 1, 1,
        32'hA000_0002, 1'b0);
    txn(2'b11, REQ_IFETCH, 1'b1, 0, 2,
        32'hA000_0003, 1'b0);
    txn(2'b11, REQ_DATA, 1'b0, 2, 0,
        32'hA000_0004, 1'b0);

    // Single fetch.
    bus.req_addr[31:0] = 32'h0000_0100;
    txn(2'b01, REQ_IFETCH, 1'b0, 0, 0,
        32'hDEAD_BEEF, 1'b0);

    // Write with delayed grant.
    bus.req_we          = 2'b10;
    bus.req_addr[63:32] = 32'h0000_2000;
    bus.req_wdata[63:32] = 32'h55AA_55AA;
    txn(2'b10, REQ_DATA, 1'b0, 5, 0,
        32'hFFFF_0000, 1'b0);
    bus.req_we = 2'b00;

    // Timeout, then rvalid on the expiry cycle.
    txn(2'b01, REQ_IFETCH, 1'b0, 0, -1,
        32'hCAFE_0001, 1'b1);
    txn(2'b10, REQ_DATA, 1'b0, 1, TO,
        32'hCAFE_0002, 1'b0);

    // Reset while in ISSUE: mem_req drops at once.
    bus.req_addr[31:0] = 32'h0000_0300;
    bus.req_valid = 2'b01;
    step();
    bus.req_valid = 2'b00;
    chk("pre_rst_mreq", 64'(bus.mem_req), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_issue_mreq", 64'(bus.mem_req), 0);
    chk("rst_issue_addr", 64'(bus.mem_addr), 0);
    #3 rst_n = 1'b1;
    step();

    // Reset while in WAIT: no response follows.
    bus.req_valid = 2'b01;
    step();
    bus.req_valid = 2'b00;
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hBAD0_BAD0;
    step();
    chk("rst_wait_resp", 64'(bus.resp_valid), 0);
    bus.mem_rvalid = 1'b0;
    #2 rst_n = 1'b1;
    step();
    step();
    chk("post_rst_resp", 64'(bus.resp_valid), 0);
    chk("post_rst_mreq", 64'(bus.mem_req), 0);

    // Reset restores requester 0 as tie winner.
    txn(2'b11, REQ_IFETCH, 1'b0, 0, 0,
        32'h0BAD_F00D, 1'b0);

    step();
    chk("sb_empty", 64'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
